// File: rtl/geofence_feeder_pkg.sv
// Shared constants, types and state encoding for the geofence feeder.
package geofence_feeder_pkg;

   localparam int unsigned CoordW         = 10;
   localparam int unsigned PointsPerFrame = 7;
   localparam int unsigned PtrW           = 3;
   localparam int unsigned DefaultTimeout = 64;

   localparam logic [PtrW-1:0] LastPt = PtrW'(PointsPerFrame - 1);

   typedef logic [CoordW-1:0] coord_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } point_t;

   typedef enum logic [2:0] {
      StSync,
      StSend,
      StWait,
      StStall,
      StHalt
   } state_e;

   // Point index advance with wrap after the last point of a frame.
   function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] ptr);
      return (ptr == LastPt) ? '0 : ptr + 1'b1;
   endfunction

endpackage

// File: rtl/geofence_feeder_if.sv
// Loader-to-feeder point handshake.
interface geofence_feeder_if;
   import geofence_feeder_pkg::*;

   logic   ld_valid;
   logic   ld_ready;
   coord_t ld_x;
   coord_t ld_y;

   modport master (
      output ld_valid,
      output ld_x,
      output ld_y,
      input  ld_ready
   );

   modport slave (
      input  ld_valid,
      input  ld_x,
      input  ld_y,
      output ld_ready
   );

endinterface

// File: rtl/geofence_frame_buf.sv
// Ping-pong frame buffer: two slots of seven points, filled by the loader and
// drained by the feeder FSM. The read port looks ahead into the other slot
// when the current send slot is being freed, so the next frame's first point
// is available in the same cycle.
module geofence_frame_buf
   import geofence_feeder_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   wr_en,
   input  point_t wr_data,
   input  logic   rd_inc,
   input  logic   rd_free,
   output logic   fill_full,
   output logic   rd_avail,
   output point_t rd_data
);

   point_t          mem [2][PointsPerFrame];
   logic [1:0]      full_q, full_d;
   logic            fill_slot_q;
   logic            send_slot_q;
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic            rd_slot;
   logic [PtrW-1:0] rd_idx;
   logic            wr_last;

   // Read port selection and full-flag next state.
   always_comb begin
      fill_full = full_q[fill_slot_q];
      rd_slot   = rd_free ? ~send_slot_q : send_slot_q;
      rd_idx    = rd_free ? '0 : rd_ptr_q;
      rd_avail  = full_q[rd_slot];
      rd_data   = mem[rd_slot][rd_idx];
      wr_last   = wr_en && (wr_ptr_q == LastPt);
      full_d    = full_q;
      if (rd_free) full_d[send_slot_q] = 1'b0;
      if (wr_last) full_d[fill_slot_q] = 1'b1;
   end

   // Point storage; contents are don't-care until the slot is marked full.
   always_ff @(posedge clk) begin
      if (wr_en) mem[fill_slot_q][wr_ptr_q] <= wr_data;
   end

   // Slot pointers and full flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_q      <= '0;
         fill_slot_q <= 1'b0;
         send_slot_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         full_q <= full_d;
         if (wr_en) begin
            wr_ptr_q <= next_ptr(wr_ptr_q);
            if (wr_last) fill_slot_q <= ~fill_slot_q;
         end
         if (rd_free) begin
            send_slot_q <= ~send_slot_q;
            // Point 0 of the new slot is consumed in this same cycle when sending restarts.
            rd_ptr_q    <= rd_inc ? PtrW'(1) : '0;
         end else if (rd_inc) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
      end
   end

endmodule

// File: rtl/geofence_feeder.sv
// Streams buffered 7-point frames to a geofence receiver, collects the
// per-frame inside/outside result and tracks sticky fault conditions.
module geofence_feeder
   import geofence_feeder_pkg::*;
#(
   parameter int unsigned TIMEOUT = DefaultTimeout
) (
   input  logic              clk,
   input  logic              reset,
   geofence_feeder_if.slave  ld,
   output coord_t            X,
   output coord_t            Y,
   input  logic              valid,
   input  logic              is_inside,
   output logic              res_valid,
   output logic              res_inside,
   output logic [7:0]        res_frame_id,
   output logic [15:0]       inside_cnt,
   output logic              underrun,
   output logic              timeout,
   output logic              proto_err
);

   localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

   state_e          state_q;
   coord_t          x_q, y_q;
   logic [PtrW-1:0] snd_cnt_q;
   logic [WaitW-1:0] wait_cnt_q;
   logic            res_valid_q, res_inside_q;
   logic [7:0]      res_frame_id_q;
   logic [15:0]     inside_cnt_q;
   logic            underrun_q, timeout_q, proto_err_q;

   logic            ld_ready_c;
   logic            wr_en;
   logic            capture;
   logic            send_start;
   logic            rd_inc;
   logic            fill_full;
   logic            rd_avail;
   point_t          rd_data;

   // Handshake and buffer control derived from current state.
   always_comb begin
      ld_ready_c = ~fill_full && (state_q != StHalt);
      wr_en      = ld.ld_valid && ld_ready_c;
      capture    = (state_q == StWait) && valid;
      send_start = rd_avail &&
                   ((state_q == StSync) || (state_q == StStall) || capture);
      rd_inc     = send_start || ((state_q == StSend) && (snd_cnt_q != LastPt));
   end

   assign ld.ld_ready   = ld_ready_c;
   assign X             = x_q;
   assign Y             = y_q;
   assign res_valid     = res_valid_q;
   assign res_inside    = res_inside_q;
   assign res_frame_id  = res_frame_id_q;
   assign inside_cnt    = inside_cnt_q;
   assign underrun      = underrun_q;
   assign timeout       = timeout_q;
   assign proto_err     = proto_err_q;

   geofence_frame_buf u_buf (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_data   ({ld.ld_x, ld.ld_y}),
      .rd_inc    (rd_inc),
      .rd_free   (capture),
      .fill_full (fill_full),
      .rd_avail  (rd_avail),
      .rd_data   (rd_data)
   );

   // Send/wait FSM with registered coordinate stream, result and fault flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StSync;
         x_q            <= '0;
         y_q            <= '0;
         snd_cnt_q      <= '0;
         wait_cnt_q     <= '0;
         res_valid_q    <= 1'b0;
         res_inside_q   <= 1'b0;
         res_frame_id_q <= '0;
         inside_cnt_q   <= '0;
         underrun_q     <= 1'b0;
         timeout_q      <= 1'b0;
         proto_err_q    <= 1'b0;
      end else begin
         res_valid_q <= 1'b0;
         // Frame id advances once the pulse carrying it has been seen.
         if (res_valid_q) res_frame_id_q <= res_frame_id_q + 8'd1;
         if (valid && ((state_q == StSync) || (state_q == StSend) || (state_q == StStall))) begin
            proto_err_q <= 1'b1;
         end
         case (state_q)
            StSync, StStall: begin
               if (rd_avail) begin
                  state_q   <= StSend;
                  x_q       <= rd_data.x;
                  y_q       <= rd_data.y;
                  snd_cnt_q <= '0;
               end else begin
                  state_q    <= StStall;
                  underrun_q <= 1'b1;
                  x_q        <= '0;
                  y_q        <= '0;
               end
            end
            StSend: begin
               if (snd_cnt_q == LastPt) begin
                  state_q    <= StWait;
                  x_q        <= '0;
                  y_q        <= '0;
                  wait_cnt_q <= '0;
               end else begin
                  snd_cnt_q <= snd_cnt_q + 1'b1;
                  x_q       <= rd_data.x;
                  y_q       <= rd_data.y;
               end
            end
            StWait: begin
               if (valid) begin
                  res_valid_q  <= 1'b1;
                  res_inside_q <= is_inside;
                  if (is_inside && (inside_cnt_q != 16'hFFFF)) begin
                     inside_cnt_q <= inside_cnt_q + 16'd1;
                  end
                  if (rd_avail) begin
                     state_q   <= StSend;
                     x_q       <= rd_data.x;
                     y_q       <= rd_data.y;
                     snd_cnt_q <= '0;
                  end else begin
                     state_q    <= StStall;
                     underrun_q <= 1'b1;
                  end
               end else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
                  timeout_q <= 1'b1;
                  state_q   <= StHalt;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            StHalt: begin
               x_q <= '0;
               y_q <= '0;
            end
            default: state_q <= StSync;
         endcase
      end
   end

endmodule

// File: tb/tb_geofence_feeder.sv
// Directed scenario bench for geofence_feeder.
module tb_geofence_feeder;
   import geofence_feeder_pkg::*;

   logic        clk;
   logic        reset;
   logic        valid;
   logic        is_inside;
   coord_t      X, Y;
   logic        res_valid, res_inside;
   logic [7:0]  res_frame_id;
   logic [15:0] inside_cnt;
   logic        underrun, timeout, proto_err;

   int tests_run;
   int tests_failed;

   coord_t fa_x [7] = '{10'd500, 10'd400, 10'd600, 10'd700, 10'd600, 10'd400, 10'd300};
   coord_t fa_y [7] = '{10'd500, 10'd400, 10'd400, 10'd500, 10'd600, 10'd600, 10'd500};
   coord_t fb_x [7] = '{10'd11, 10'd22, 10'd33, 10'd44, 10'd55, 10'd66, 10'd77};
   coord_t fb_y [7] = '{10'd101, 10'd202, 10'd303, 10'd404, 10'd505, 10'd606, 10'd707};

   geofence_feeder_if ld_if ();

   geofence_feeder #(.TIMEOUT(64)) dut (
      .clk          (clk),
      .reset        (reset),
      .ld           (ld_if),
      .X            (X),
      .Y            (Y),
      .valid        (valid),
      .is_inside    (is_inside),
      .res_valid    (res_valid),
      .res_inside   (res_inside),
      .res_frame_id (res_frame_id),
      .inside_cnt   (inside_cnt),
      .underrun     (underrun),
      .timeout      (timeout),
      .proto_err    (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   task automatic do_reset();
      reset = 1'b1;
      valid = 1'b0;
      is_inside = 1'b0;
      ld_if.ld_valid = 1'b0;
      ld_if.ld_x = '0;
      ld_if.ld_y = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Offers one frame on the loader port; returns at the negedge after the last handshake.
   task automatic load_frame(input bit second);
      int n;
      for (int i = 0; i < 7; i++) begin
         ld_if.ld_valid = 1'b1;
         ld_if.ld_x = second ? fb_x[i] : fa_x[i];
         ld_if.ld_y = second ? fb_y[i] : fa_y[i];
         n = 0;
         while (ld_if.ld_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (n == 200) begin
            tests_run++;
            tests_failed++;
            $display("FAIL load_ready: got ld_ready=%b expected 1 within 200 cycles", ld_if.ld_ready);
         end
         @(negedge clk);
      end
      ld_if.ld_valid = 1'b0;
   endtask

   task automatic wait_point(input coord_t x, input coord_t y, output bit found);
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (X === x && Y === y) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      valid = 1'b0;
      is_inside = 1'b0;
      ld_if.ld_valid = 1'b0;
      ld_if.ld_x = '0;
      ld_if.ld_y = '0;
      #1;
      tests_run++;
      if ({X, Y, res_valid, res_inside, res_frame_id, inside_cnt, underrun, timeout, proto_err}
          !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got X=%0d Y=%0d rv=%b ri=%b id=%0d cnt=%0d u=%b t=%b p=%b expected all 0",
                  X, Y, res_valid, res_inside, res_frame_id, inside_cnt, underrun, timeout,
                  proto_err);
      end
      tests_run++;
      if (ld_if.ld_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ld_ready: got %b expected 1", ld_if.ld_ready);
      end
      tests_run++;
      if (dut.state_q !== StSync) begin
         tests_failed++;
         $display("FAIL reset_state: got %0d expected %0d", dut.state_q, StSync);
      end
      @(negedge clk);
   endtask

   task automatic test_single_frame();
      bit found;
      do_reset();
      fork
         load_frame(1'b0);
         begin
            wait_point(fa_x[0], fa_y[0], found);
            tests_run++;
            if (!found) begin
               tests_failed++;
               $display("FAIL s1_first_point: got X=%0d Y=%0d expected 500,500", X, Y);
            end else begin
               for (int i = 1; i < 7; i++) begin
                  @(negedge clk);
                  tests_run++;
                  if ({X, Y} !== {fa_x[i], fa_y[i]}) begin
                     tests_failed++;
                     $display("FAIL s1_point%0d: got %0d,%0d expected %0d,%0d", i, X, Y,
                              fa_x[i], fa_y[i]);
                  end
               end
               repeat (3) @(negedge clk);
               valid = 1'b1;
               is_inside = 1'b1;
               @(negedge clk);
               valid = 1'b0;
               is_inside = 1'b0;
               tests_run++;
               if ({res_valid, res_inside} !== 2'b11) begin
                  tests_failed++;
                  $display("FAIL s1_result: got rv=%b ri=%b expected 1 1", res_valid, res_inside);
               end
               tests_run++;
               if (inside_cnt !== 16'd1) begin
                  tests_failed++;
                  $display("FAIL s1_inside_cnt: got %0d expected 1", inside_cnt);
               end
               tests_run++;
               if (res_frame_id !== 8'd0) begin
                  tests_failed++;
                  $display("FAIL s1_frame_id: got %0d expected 0", res_frame_id);
               end
               @(negedge clk);
               tests_run++;
               if ({res_valid, res_frame_id} !== {1'b0, 8'd1}) begin
                  tests_failed++;
                  $display("FAIL s1_after_pulse: got rv=%b id=%0d expected 0 1", res_valid,
                           res_frame_id);
               end
            end
         end
      join
   endtask

   task automatic test_back_to_back();
      bit found;
      do_reset();
      fork
         begin
            load_frame(1'b0);
            load_frame(1'b1);
         end
         begin
            wait_point(fa_x[0], fa_y[0], found);
            tests_run++;
            if (!found) begin
               tests_failed++;
               $display("FAIL s2_first_point: got X=%0d Y=%0d expected 500,500", X, Y);
            end else begin
               for (int i = 1; i < 7; i++) begin
                  @(negedge clk);
                  tests_run++;
                  if ({X, Y} !== {fa_x[i], fa_y[i]}) begin
                     tests_failed++;
                     $display("FAIL s2_a_point%0d: got %0d,%0d expected %0d,%0d", i, X, Y,
                              fa_x[i], fa_y[i]);
                  end
               end
               repeat (3) @(negedge clk);
               valid = 1'b1;
               is_inside = 1'b0;
               @(negedge clk);
               valid = 1'b0;
               tests_run++;
               if ({X, Y} !== {fb_x[0], fb_y[0]}) begin
                  tests_failed++;
                  $display("FAIL s2_b_point0: got %0d,%0d expected %0d,%0d", X, Y, fb_x[0],
                           fb_y[0]);
               end
               tests_run++;
               if (dut.state_q !== StSend) begin
                  tests_failed++;
                  $display("FAIL s2_no_stall: got state %0d expected %0d", dut.state_q, StSend);
               end
               tests_run++;
               if ({res_valid, res_inside, inside_cnt} !== {2'b10, 16'd0}) begin
                  tests_failed++;
                  $display("FAIL s2_a_result: got rv=%b ri=%b cnt=%0d expected 1 0 0", res_valid,
                           res_inside, inside_cnt);
               end
               for (int i = 1; i < 7; i++) begin
                  @(negedge clk);
                  tests_run++;
                  if ({X, Y} !== {fb_x[i], fb_y[i]}) begin
                     tests_failed++;
                     $display("FAIL s2_b_point%0d: got %0d,%0d expected %0d,%0d", i, X, Y,
                              fb_x[i], fb_y[i]);
                  end
               end
               repeat (3) @(negedge clk);
               valid = 1'b1;
               is_inside = 1'b1;
               @(negedge clk);
               valid = 1'b0;
               is_inside = 1'b0;
               tests_run++;
               if ({res_valid, res_frame_id, inside_cnt} !== {1'b1, 8'd1, 16'd1}) begin
                  tests_failed++;
                  $display("FAIL s2_b_result: got rv=%b id=%0d cnt=%0d expected 1 1 1", res_valid,
                           res_frame_id, inside_cnt);
               end
            end
         end
      join
   endtask

   task automatic test_underrun();
      bit found;
      do_reset();
      repeat (10) @(negedge clk);
      tests_run++;
      if (dut.state_q !== StStall) begin
         tests_failed++;
         $display("FAIL s3_state: got %0d expected %0d", dut.state_q, StStall);
      end
      tests_run++;
      if ({underrun, X, Y} !== {1'b1, 20'd0}) begin
         tests_failed++;
         $display("FAIL s3_underrun: got u=%b X=%0d Y=%0d expected 1 0 0", underrun, X, Y);
      end
      fork
         load_frame(1'b1);
         begin
            wait_point(fb_x[0], fb_y[0], found);
            tests_run++;
            if (!found) begin
               tests_failed++;
               $display("FAIL s3_first_point: got X=%0d Y=%0d expected %0d,%0d", X, Y, fb_x[0],
                        fb_y[0]);
            end else begin
               for (int i = 1; i < 7; i++) begin
                  @(negedge clk);
                  tests_run++;
                  if ({X, Y} !== {fb_x[i], fb_y[i]}) begin
                     tests_failed++;
                     $display("FAIL s3_point%0d: got %0d,%0d expected %0d,%0d", i, X, Y,
                              fb_x[i], fb_y[i]);
                  end
               end
            end
         end
      join
   endtask

   task automatic test_timeout();
      bit found;
      do_reset();
      fork
         load_frame(1'b0);
         begin
            wait_point(fa_x[0], fa_y[0], found);
            tests_run++;
            if (!found) begin
               tests_failed++;
               $display("FAIL s4_first_point: got X=%0d Y=%0d expected 500,500", X, Y);
            end else begin
               repeat (6) @(negedge clk);
               repeat (64) @(negedge clk);
               tests_run++;
               if ({timeout, dut.state_q} !== {1'b0, StWait}) begin
                  tests_failed++;
                  $display("FAIL s4_last_wait: got t=%b state=%0d expected 0 %0d", timeout,
                           dut.state_q, StWait);
               end
               @(negedge clk);
               tests_run++;
               if ({timeout, ld_if.ld_ready, X, Y} !== {2'b10, 20'd0}) begin
                  tests_failed++;
                  $display("FAIL s4_timeout: got t=%b rdy=%b X=%0d Y=%0d expected 1 0 0 0",
                           timeout, ld_if.ld_ready, X, Y);
               end
               tests_run++;
               if (dut.state_q !== StHalt) begin
                  tests_failed++;
                  $display("FAIL s4_halt: got %0d expected %0d", dut.state_q, StHalt);
               end
               valid = 1'b1;
               repeat (5) @(negedge clk);
               valid = 1'b0;
               tests_run++;
               if ({dut.state_q, res_valid, ld_if.ld_ready} !== {StHalt, 2'b00}) begin
                  tests_failed++;
                  $display("FAIL s4_halt_hold: got state=%0d rv=%b rdy=%b expected %0d 0 0",
                           dut.state_q, res_valid, ld_if.ld_ready, StHalt);
               end
            end
         end
      join
   endtask

   task automatic test_proto_err();
      bit found;
      do_reset();
      fork
         load_frame(1'b0);
         begin
            wait_point(fa_x[0], fa_y[0], found);
            tests_run++;
            if (!found) begin
               tests_failed++;
               $display("FAIL s5_first_point: got X=%0d Y=%0d expected 500,500", X, Y);
            end else begin
               tests_run++;
               if (proto_err !== 1'b0) begin
                  tests_failed++;
                  $display("FAIL s5_before: got proto_err=%b expected 0", proto_err);
               end
               valid = 1'b1;
               is_inside = 1'b1;
               for (int i = 1; i < 7; i++) begin
                  @(negedge clk);
                  valid = 1'b0;
                  is_inside = 1'b0;
                  tests_run++;
                  if ({X, Y} !== {fa_x[i], fa_y[i]}) begin
                     tests_failed++;
                     $display("FAIL s5_point%0d: got %0d,%0d expected %0d,%0d", i, X, Y,
                              fa_x[i], fa_y[i]);
                  end
               end
               tests_run++;
               if ({proto_err, res_valid, inside_cnt} !== {2'b10, 16'd0}) begin
                  tests_failed++;
                  $display("FAIL s5_proto: got p=%b rv=%b cnt=%0d expected 1 0 0", proto_err,
                           res_valid, inside_cnt);
               end
               @(negedge clk);
               tests_run++;
               if (dut.state_q !== StWait) begin
                  tests_failed++;
                  $display("FAIL s5_wait: got %0d expected %0d", dut.state_q, StWait);
               end
            end
         end
      join
   endtask

   task automatic test_reset_mid_frame();
      bit found;
      do_reset();
      fork
         load_frame(1'b0);
         begin
            wait_point(fa_x[0], fa_y[0], found);
            tests_run++;
            if (!found) begin
               tests_failed++;
               $display("FAIL s6_first_point: got X=%0d Y=%0d expected 500,500", X, Y);
            end
            repeat (3) @(negedge clk);
            tests_run++;
            if ({X, Y} !== {fa_x[3], fa_y[3]}) begin
               tests_failed++;
               $display("FAIL s6_point3: got %0d,%0d expected 700,500", X, Y);
            end
            reset = 1'b1;
            #1;
            tests_run++;
            if ({X, Y, res_valid, res_inside, res_frame_id, inside_cnt, underrun, timeout,
                 proto_err} !== '0) begin
               tests_failed++;
               $display("FAIL s6_reset_outputs: got X=%0d Y=%0d u=%b cnt=%0d expected all 0",
                        X, Y, underrun, inside_cnt);
            end
            tests_run++;
            if ({ld_if.ld_ready, dut.state_q} !== {1'b1, StSync}) begin
               tests_failed++;
               $display("FAIL s6_reset_state: got rdy=%b state=%0d expected 1 %0d",
                        ld_if.ld_ready, dut.state_q, StSync);
            end
         end
      join
      @(negedge clk);
      reset = 1'b0;
      load_frame(1'b1);
      wait_point(fb_x[0], fb_y[0], found);
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL s6_new_point0: got X=%0d Y=%0d expected %0d,%0d", X, Y, fb_x[0],
                  fb_y[0]);
      end else begin
         for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            tests_run++;
            if ({X, Y} !== {fb_x[i], fb_y[i]}) begin
               tests_failed++;
               $display("FAIL s6_new_point%0d: got %0d,%0d expected %0d,%0d", i, X, Y,
                        fb_x[i], fb_y[i]);
            end
         end
         repeat (3) @(negedge clk);
         valid = 1'b1;
         is_inside = 1'b1;
         @(negedge clk);
         valid = 1'b0;
         is_inside = 1'b0;
         tests_run++;
         if ({res_valid, res_inside, res_frame_id, inside_cnt} !== {2'b11, 8'd0, 16'd1}) begin
            tests_failed++;
            $display("FAIL s6_result: got rv=%b ri=%b id=%0d cnt=%0d expected 1 1 0 1",
                     res_valid, res_inside, res_frame_id, inside_cnt);
         end
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_underrun();
      test_timeout();
      test_proto_err();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/geofence_feeder.md
GEOFENCE_FEEDER -- requirements
Module: geofence_feeder

Interface
REQ-001 Parameter TIMEOUT, default 64, max cycles in WAIT for receiver valid before fault.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ld_valid  input  1  loader offers one point (ld_x, ld_y).
REQ-005 ld_ready  output  1  feeder accepts a point this cycle (handshake = ld_valid & ld_ready).
REQ-006 ld_x, ld_y  input  10 each  point coordinates; per frame, the 1st point is the target, the 2nd to 7th are receivers.
REQ-007 X, Y  output  10 each  coordinate stream to the geofence receiver.
REQ-008 valid  input  1  receiver result strobe, sampled on rising clk.
REQ-009 is_inside  input  1  receiver result, qualified by valid.
REQ-010 res_valid  output  1  one-cycle pulse: frame result captured.
REQ-011 res_inside  output  1  captured is_inside for that frame.
REQ-012 res_frame_id  output  8  frame index of the result; wraps 255->0.
REQ-013 inside_cnt  output  16  count of inside results; saturates at 65535.
REQ-014 underrun, timeout, proto_err  output  1 each  sticky fault flags.

Function
REQ-015 Buffer: two 7-point frame slots (ping-pong); a write pointer (0..6) selects the point within the fill slot; the 7th accepted point marks the slot full and switches fill to the other slot.
REQ-016 ld_ready = 1 while the fill slot is not full and the state is not HALT; with both slots full, ld_ready = 0.
REQ-017 States: SYNC, SEND, WAIT, STALL, HALT; reset enters SYNC.
REQ-018 SYNC lasts exactly 1 cycle (receiver idle cycle), then goes to SEND if the send slot is full, else to STALL.
REQ-019 SEND: drive point k of the send slot on X/Y for cycle k, k = 0..6, over 7 consecutive cycles with no gaps; after k = 6, go to WAIT.
REQ-020 STALL: entered when SEND must begin but no full slot exists; set underrun; X/Y = 0; go to SEND the cycle after a slot becomes full.
REQ-021 WAIT: count cycles; on valid = 1, capture is_inside, pulse res_valid next cycle, free the send slot, toggle the send slot, and increment res_frame_id after reporting.
REQ-022 After the valid edge, the next frame's point 0 is driven in the immediately following cycle (SEND if that slot is full, else STALL).
REQ-023 inside_cnt increments by 1 per captured is_inside = 1 and holds at 16'hFFFF.
REQ-024 The WAIT counter reaching TIMEOUT without valid sets timeout and goes to HALT; HALT holds X/Y = 0 and ld_ready = 0 until reset.
REQ-025 valid = 1 sampled in SEND, STALL or SYNC sets proto_err and is otherwise ignored.
REQ-026 A point accepted in the same cycle that a slot is freed fills the correct slot with no loss; a freed slot is reusable the next cycle.
REQ-027 During SEND, X/Y change only at rising edges; the values are stable for the whole cycle.

Reset
REQ-028 On reset, all of these are 0: X, Y, res_valid, res_inside, res_frame_id, inside_cnt, underrun, timeout, proto_err, pointers, slot-full flags, WAIT counter.
REQ-029 On reset, ld_ready is 1.
REQ-030 Reset mid-frame discards both slots and any partial frame; the state returns to SYNC.

Structure
REQ-031 The shared package holds: the coordinate width (10), the points-per-frame count (7), the state encoding, and the default TIMEOUT.
REQ-032 The frame buffer is one sub-module, geofence_frame_buf, with 2x7x20-bit storage, write/read pointers and full flags; the FSM and counters stay at the top level.

Verification
REQ-033 Scenario 1: load the frame (500,500),(400,400),(600,400),(700,500),(600,600),(400,600),(300,500); the receiver model asserts valid with is_inside = 1 at 3 cycles after the last point. Required: X/Y sequence exactly as loaded, starting the cycle after SYNC; res_valid = 1 and res_inside = 1; inside_cnt = 1; res_frame_id = 0.
REQ-034 Scenario 2: two frames preloaded back-to-back. Required: frame 2 point 0 is driven in the cycle after valid; no underrun.
REQ-035 Scenario 3: no frame loaded for 10 cycles after reset. Required: STALL entered; underrun = 1; X/Y = 0; the frame sends once loaded.
REQ-036 Scenario 4: valid is never asserted. Required: timeout = 1 after 64 WAIT cycles; ld_ready = 0; state HALT.
REQ-037 Scenario 5: valid pulsed during SEND. Required: proto_err = 1; the stream continues unchanged.
REQ-038 Scenario 6: reset asserted at SEND point 3. Required: all outputs at their reset values; the subsequent frame sends correctly.
